// File: rtl/virtual_source.sv
// Synthetic cast-traffic injector: bursts of sequence-numbered flits tagged with (x, y).
// Optional macro VIRTUAL_SOURCE_DISPLAY_EN prints start/finish messages on the first/final handshake.
module virtual_source #(
    parameter int total_flits = 1000,
    parameter int burst_len   = 8,
    parameter int gap_len     = 0,
    parameter int start_delay = 0,
    parameter int x           = 0,
    parameter int y           = 0,
    parameter int DW          = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [15:0]   sent_cnt_o
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SEND, S_GAP, S_DONE} state_t;

    localparam int DMAX = (start_delay > gap_len) ? start_delay : gap_len;
    localparam int DCW  = (DMAX > 1) ? $clog2(DMAX + 1) : 1;
    localparam int BCW  = (burst_len > 1) ? $clog2(burst_len + 1) : 1;

    localparam logic [DCW-1:0] DLY_END   = DCW'(start_delay);
    localparam logic [DCW-1:0] GAP_END   = DCW'((gap_len > 0) ? gap_len - 1 : 0);
    localparam logic [BCW-1:0] BURST_END = BCW'(burst_len - 1);
    localparam logic [16:0]    TOTAL     = 17'(total_flits);

    if (DW < 32) begin : g_dw_check
        $error("virtual_source: DW must be at least 32");
    end

    state_t          r_state;
    logic [DCW-1:0]  r_dly;
    logic [BCW-1:0]  r_burst;

    state_t          w_state_nx;
    logic [DCW-1:0]  w_dly_nx;
    logic [BCW-1:0]  w_burst_nx;
    logic [15:0]     w_cnt_nx;
    logic [16:0]     w_cnt_inc;
    logic [DW-1:0]   w_data_nx;
    logic            w_valid_nx;
    logic            w_busy_nx;
    logic            w_done_nx;
    logic            w_load;
    logic            w_hs;

    function automatic logic [DW-1:0] f_payload(input logic [15:0] seq);
        logic [DW-1:0] p;
        p        = '0;
        p[31:24] = 8'(x);
        p[23:16] = 8'(y);
        p[15:0]  = seq;
        return p;
    endfunction

    // w_load presents a new flit on the next edge, numbered with the post-edge sent count.
    always_comb begin
        w_state_nx = r_state;
        w_dly_nx   = r_dly;
        w_burst_nx = r_burst;
        w_cnt_nx   = sent_cnt_o;
        w_data_nx  = data_o;
        w_valid_nx = valid_o;
        w_load     = 1'b0;
        w_hs       = valid_o && ready_i && (r_state == S_SEND);
        w_cnt_inc  = {1'b0, sent_cnt_o} + 17'd1;

        case (r_state)
            S_IDLE: begin
                w_dly_nx = '0;
                if (start_i) begin
                    if (start_delay > 0) w_state_nx = S_WAIT;
                    else                 w_state_nx = S_SEND;
                end
            end
            S_WAIT: begin
                if (r_dly == DLY_END) begin
                    w_state_nx = S_SEND;
                    w_dly_nx   = '0;
                    w_load     = 1'b1;
                end else begin
                    w_dly_nx = r_dly + DCW'(1);
                end
            end
            S_SEND: begin
                if (!valid_o) begin
                    w_load = 1'b1;
                end else if (w_hs) begin
                    w_cnt_nx = w_cnt_inc[15:0];
                    if (w_cnt_inc == TOTAL) begin
                        w_state_nx = S_DONE;
                        w_valid_nx = 1'b0;
                    end else if (r_burst == BURST_END) begin
                        w_burst_nx = '0;
                        if (gap_len > 0) begin
                            w_state_nx = S_GAP;
                            w_valid_nx = 1'b0;
                            w_dly_nx   = '0;
                        end else begin
                            w_load = 1'b1;
                        end
                    end else begin
                        w_burst_nx = r_burst + BCW'(1);
                        w_load     = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (r_dly == GAP_END) begin
                    w_state_nx = S_SEND;
                    w_dly_nx   = '0;
                    w_load     = 1'b1;
                end else begin
                    w_dly_nx = r_dly + DCW'(1);
                end
            end
            S_DONE: begin
                w_state_nx = S_DONE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        if (w_load) begin
            w_valid_nx = 1'b1;
            w_data_nx  = f_payload(w_cnt_nx);
        end
        w_busy_nx = (w_state_nx == S_WAIT) || (w_state_nx == S_SEND) || (w_state_nx == S_GAP);
        w_done_nx = (w_state_nx == S_DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_dly      <= '0;
            r_burst    <= '0;
            sent_cnt_o <= '0;
            data_o     <= '0;
            valid_o    <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_dly      <= w_dly_nx;
            r_burst    <= w_burst_nx;
            sent_cnt_o <= w_cnt_nx;
            data_o     <= w_data_nx;
            valid_o    <= w_valid_nx;
            busy_o     <= w_busy_nx;
            done_o     <= w_done_nx;
        end
    end

`ifdef VIRTUAL_SOURCE_DISPLAY_EN
    always_ff @(posedge clk) begin
        if (rstn && w_hs) begin
            if (sent_cnt_o == 16'd0)
                $display("time %0t: source (%0d, %0d) start injecting ...", $time, x, y);
            if (w_cnt_inc == TOTAL)
                $display("time %0t: source (%0d, %0d) finished injecting ...", $time, x, y);
        end
    end
`else
`endif

endmodule

// File: tb/tb_virtual_source.sv
// Directed bench for virtual_source: instance A (20 flits, one burst, no delay),
// instance B (12 flits, bursts of 4, gap 3, delay 2, x=3, y=5, 40-bit payload).
module tb_virtual_source;

    logic        clk = 1'b0;
    logic        rstn;
    logic        startA, readyA, validA, busyA, doneA;
    logic [31:0] dataA;
    logic [15:0] sentA;
    logic        startB, readyB, validB, busyB, doneB;
    logic [39:0] dataB;
    logic [15:0] sentB;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    virtual_source #(.total_flits(20), .burst_len(20), .gap_len(0), .start_delay(0),
                     .x(0), .y(0), .DW(32)) u_a (
        .clk(clk), .rstn(rstn), .start_i(startA), .data_o(dataA), .valid_o(validA),
        .ready_i(readyA), .busy_o(busyA), .done_o(doneA), .sent_cnt_o(sentA));

    virtual_source #(.total_flits(12), .burst_len(4), .gap_len(3), .start_delay(2),
                     .x(3), .y(5), .DW(40)) u_b (
        .clk(clk), .rstn(rstn), .start_i(startB), .data_o(dataB), .valid_o(validB),
        .ready_i(readyB), .busy_o(busyB), .done_o(doneB), .sent_cnt_o(sentB));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        #3;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; startA = 1'b0; readyA = 1'b0; startB = 1'b0; readyB = 1'b0;
        #1;
        n_vec++; if (validA !== 1'b0 || dataA !== 32'h0) begin n_err++; $display("FAIL reset_A_valid_data: got %b/%h want 0/0", validA, dataA); end
        n_vec++; if (busyA !== 1'b0 || doneA !== 1'b0) begin n_err++; $display("FAIL reset_A_busy_done: got %b/%b want 0/0", busyA, doneA); end
        n_vec++; if (sentA !== 16'd0) begin n_err++; $display("FAIL reset_A_sent: got %0d want 0", sentA); end
        n_vec++; if (validB !== 1'b0 || dataB !== 40'h0) begin n_err++; $display("FAIL reset_B_valid_data: got %b/%h want 0/0", validB, dataB); end
        n_vec++; if (busyB !== 1'b0 || doneB !== 1'b0 || sentB !== 16'd0) begin n_err++; $display("FAIL reset_B_ctrl: got %b/%b/%0d want 0/0/0", busyB, doneB, sentB); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        readyA = 1'b1; startA = 1'b1;
        tick();
        startA = 1'b0;
        n_vec++; if (validA !== 1'b0 || busyA !== 1'b1) begin n_err++; $display("FAIL basic_edge0: got valid %b busy %b want 0/1", validA, busyA); end
        for (int c = 1; c <= 20; c++) begin
            tick();
            n_vec++; if (validA !== 1'b1 || dataA !== 32'(c - 1)) begin n_err++; $display("FAIL basic_flit%0d: got valid %b data %h want 1/%h", c, validA, dataA, 32'(c - 1)); end
            n_vec++; if (sentA !== 16'(c - 1)) begin n_err++; $display("FAIL basic_cnt%0d: got %0d want %0d", c, sentA, c - 1); end
        end
        tick();
        n_vec++; if (validA !== 1'b0 || doneA !== 1'b1 || busyA !== 1'b0) begin n_err++; $display("FAIL basic_done: got valid %b done %b busy %b want 0/1/0", validA, doneA, busyA); end
        n_vec++; if (sentA !== 16'd20) begin n_err++; $display("FAIL basic_final_cnt: got %0d want 20", sentA); end
    endtask

    task automatic test_bursts();
        int  pos, k, off, eseq;
        logic ev;
        readyB = 1'b1; startB = 1'b1;
        tick();
        startB = 1'b0;
        n_vec++; if (validB !== 1'b0 || busyB !== 1'b1) begin n_err++; $display("FAIL burst_edge0: got valid %b busy %b want 0/1", validB, busyB); end
        for (int e = 1; e <= 22; e++) begin
            tick();
            pos = e - 3; ev = 1'b0; eseq = 0;
            if (pos >= 0) begin
                k = pos / 7; off = pos % 7;
                if (k < 3 && off < 4) begin ev = 1'b1; eseq = 4 * k + off; end
            end
            n_vec++; if (validB !== ev) begin n_err++; $display("FAIL burst_valid_e%0d: got %b want %b", e, validB, ev); end
            if (ev) begin
                n_vec++; if (dataB !== {8'h00, 8'h03, 8'h05, 16'(eseq)}) begin n_err++; $display("FAIL burst_data_e%0d: got %h want %h", e, dataB, {8'h00, 8'h03, 8'h05, 16'(eseq)}); end
            end
            n_vec++; if (doneB !== (e >= 21) || busyB !== (e < 21)) begin n_err++; $display("FAIL burst_flags_e%0d: got done %b busy %b want %b/%b", e, doneB, busyB, e >= 21, e < 21); end
        end
        n_vec++; if (sentB !== 16'd12) begin n_err++; $display("FAIL burst_final_cnt: got %0d want 12", sentB); end
    endtask

    task automatic test_idle_restart();
        startB = 1'b1;
        tick();
        startB = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (validB !== 1'b0 || doneB !== 1'b1 || busyB !== 1'b0 || sentB !== 16'd12) begin n_err++; $display("FAIL done_restart_%0d: got valid %b done %b busy %b cnt %0d want 0/1/0/12", i, validB, doneB, busyB, sentB); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int          eseq = 0;
        int          cyc  = 0;
        logic        stalled = 1'b0;
        logic [39:0] prev = '0;
        apply_reset();
        readyB = 1'b0; startB = 1'b1;
        tick();
        startB = 1'b0;
        while (cyc < 400 && doneB !== 1'b1) begin
            if (stalled) begin
                n_vec++; if (validB !== 1'b1 || dataB !== prev) begin n_err++; $display("FAIL bp_stable_c%0d: got %b/%h want 1/%h", cyc, validB, dataB, prev); end
            end
            if (validB) begin
                n_vec++; if (dataB !== {8'h00, 8'h03, 8'h05, 16'(eseq)}) begin n_err++; $display("FAIL bp_seq_c%0d: got %h want %h", cyc, dataB, {8'h00, 8'h03, 8'h05, 16'(eseq)}); end
            end
            readyB  = 1'($urandom_range(0, 1));
            stalled = validB && !readyB;
            prev    = dataB;
            if (validB && readyB) eseq++;
            tick();
            cyc++;
        end
        n_vec++; if (doneB !== 1'b1) begin n_err++; $display("FAIL bp_timeout: done %b after %0d cycles want 1", doneB, cyc); end
        n_vec++; if (eseq != 12 || sentB !== 16'd12) begin n_err++; $display("FAIL bp_count: got hs %0d cnt %0d want 12/12", eseq, sentB); end
        n_vec++; if (validB !== 1'b0) begin n_err++; $display("FAIL bp_final_valid: got %b want 0", validB); end
    endtask

    task automatic test_reset_midrun();
        int hs = 0;
        int i  = 0;
        apply_reset();
        readyA = 1'b1; startA = 1'b1;
        tick();
        startA = 1'b0;
        while (i < 50 && sentA !== 16'd7) begin tick(); i++; end
        n_vec++; if (sentA !== 16'd7 || validA !== 1'b1 || dataA !== 32'd7) begin n_err++; $display("FAIL mid_reach7: got cnt %0d valid %b data %h want 7/1/7", sentA, validA, dataA); end
        #2;
        rstn = 1'b0;
        #1;
        n_vec++; if (validA !== 1'b0 || dataA !== 32'h0 || busyA !== 1'b0 || doneA !== 1'b0 || sentA !== 16'd0) begin n_err++; $display("FAIL mid_async_clear: got %b/%h/%b/%b/%0d want 0/0/0/0/0", validA, dataA, busyA, doneA, sentA); end
        @(negedge clk);
        rstn = 1'b1;
        startA = 1'b1;
        tick();
        startA = 1'b0;
        tick();
        n_vec++; if (validA !== 1'b1 || dataA !== 32'd0) begin n_err++; $display("FAIL mid_restart_seq: got %b/%h want 1/0", validA, dataA); end
        i = 0;
        while (i < 100 && doneA !== 1'b1) begin
            if (validA && readyA) hs++;
            tick();
            i++;
        end
        n_vec++; if (hs != 20 || sentA !== 16'd20 || doneA !== 1'b1) begin n_err++; $display("FAIL mid_rerun: got hs %0d cnt %0d done %b want 20/20/1", hs, sentA, doneA); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bursts();
        test_idle_restart();
        test_backpressure();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
